// File: rtl/req_ack_arbiter_pkg.sv
// Shared types and helpers for the req/ack round-robin arbiter.
package req_ack_arbiter_pkg;

    localparam int unsigned MAX_REQ   = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width for n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request strictly after ptr, wrapping modulo n.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          n
    );
        int j;
        rr_pick = '0;
        // Walk from the farthest candidate inward so the nearest one wins.
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= int'(n)) begin
                j = (int'(ptr) + k) % int'(n);
                if (req[j]) rr_pick = MAX_IDX_W'(j);
            end
        end
    endfunction

endpackage

// File: rtl/req_ack_arbiter_if.sv
// Requester and shared-resource handshake bundle for req_ack_arbiter.
interface req_ack_arbiter_if
    import req_ack_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned IDX_W = idx_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             err;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             res_req;
    logic             res_ack;
    logic             busy;
    logic [CNT_W-1:0] timeout_cnt;
    logic             spurious_ack;

    modport slave (
        input  req, res_ack,
        output ack, err, gnt, gnt_idx, res_req, busy, timeout_cnt, spurious_ack
    );

    modport master (
        output req, res_ack,
        input  ack, err, gnt, gnt_idx, res_req, busy, timeout_cnt, spurious_ack
    );

endinterface

// File: rtl/req_ack_arbiter_rr_priority_picker.sv
// Combinational round-robin search: next requester after the priority pointer.
module rr_priority_picker
    import req_ack_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    logic [MAX_REQ-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] pick;

    always_comb begin
        req_ext = MAX_REQ'(req);
        pick    = rr_pick(req_ext, MAX_IDX_W'(ptr), N_REQ);
        idx_c   = IDX_W'(pick);
        valid_c = |req;
    end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto one req/ack resource
// with a bounded-latency timeout. Define REQ_ACK_ARBITER_ASSERT_EN for embedded checks.
module req_ack_arbiter
    import req_ack_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    req_ack_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = idx_w(N_REQ);
    localparam int unsigned LAT_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic [LAT_W-1:0] lat_q, lat_n;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [N_REQ-1:0] ack_q, ack_n;
    logic             err_q, err_n;
    logic             res_req_q, res_req_n;
    logic             busy_q, busy_n;
    logic [CNT_W-1:0] tcnt_q, tcnt_n;
    logic             spur_q, spur_n;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .idx_c   (pick_idx),
        .valid_c (pick_valid)
    );

    // State and registered outputs; reset aborts any open transaction silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N_REQ - 1);
            lat_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            res_req_q <= 1'b0;
            busy_q    <= 1'b0;
            tcnt_q    <= '0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            ptr_q     <= ptr_n;
            lat_q     <= lat_n;
            gnt_idx_q <= gnt_idx_n;
            gnt_q     <= gnt_n;
            ack_q     <= ack_n;
            err_q     <= err_n;
            res_req_q <= res_req_n;
            busy_q    <= busy_n;
            tcnt_q    <= tcnt_n;
            spur_q    <= spur_n;
        end
    end

    // Next-state and next-output logic; ack/err are single-cycle pulses.
    always_comb begin
        state_n   = state_q;
        ptr_n     = ptr_q;
        lat_n     = lat_q;
        gnt_idx_n = gnt_idx_q;
        gnt_n     = gnt_q;
        ack_n     = '0;
        err_n     = 1'b0;
        res_req_n = res_req_q;
        tcnt_n    = tcnt_q;
        spur_n    = spur_q | (bus.res_ack && state_q != WAIT);

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_n = pick_idx;
                    gnt_n     = N_REQ'(1) << pick_idx;
                    res_req_n = 1'b1;
                    lat_n     = '0;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (bus.res_ack) begin
                    res_req_n = 1'b0;
                    ack_n     = N_REQ'(1) << gnt_idx_q;
                    state_n   = DONE;
                end else if (lat_q == LAT_W'(TIMEOUT - 1)) begin
                    res_req_n = 1'b0;
                    ack_n     = N_REQ'(1) << gnt_idx_q;
                    err_n     = 1'b1;
                    if (tcnt_q != '1) tcnt_n = tcnt_q + CNT_W'(1);
                    state_n   = DONE;
                end else begin
                    lat_n = lat_q + LAT_W'(1);
                end
            end
            DONE: begin
                gnt_n   = '0;
                ptr_n   = gnt_idx_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = gnt_idx_q;
    assign bus.res_req      = res_req_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_cnt  = tcnt_q;
    assign bus.spurious_ack = spur_q;

`ifdef REQ_ACK_ARBITER_ASSERT_EN
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_q));
    a_res_bound:  assert property (@(posedge clk) disable iff (!rst_n)
                                   res_req_q |-> ##[1:TIMEOUT] !res_req_q);
    a_err_ack:    assert property (@(posedge clk) disable iff (!rst_n) err_q |-> |ack_q);

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_live
        a_live: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.req[i] && gnt_q == '0 && state_q == IDLE && pick_idx == IDX_W'(i))
            |-> ##[2:TIMEOUT+1] ack_q[i]);
    end
`else
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed self-checking bench for req_ack_arbiter (N_REQ=4, TIMEOUT=3, CNT_W=8).
module tb_req_ack_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned TIMEOUT = 3;
    localparam int unsigned CNT_W   = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    req_ack_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    req_ack_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.res_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_idx;
        int exp_cnt;
        n_checks = 0;
        n_err    = 0;

        // 1: reset values, then single request with res_ack one cycle later
        do_reset();
        check("rst_ack",      32'(bus.ack), 0);
        check("rst_err",      32'(bus.err), 0);
        check("rst_gnt",      32'(bus.gnt), 0);
        check("rst_gnt_idx",  32'(bus.gnt_idx), 0);
        check("rst_res_req",  32'(bus.res_req), 0);
        check("rst_busy",     32'(bus.busy), 0);
        check("rst_tcnt",     32'(bus.timeout_cnt), 0);
        check("rst_spurious", 32'(bus.spurious_ack), 0);
        bus.req = 4'b0001;
        step();
        check("t1_gnt",     32'(bus.gnt), 32'h1);
        check("t1_res_req", 32'(bus.res_req), 1);
        check("t1_busy",    32'(bus.busy), 1);
        check("t1_ack_pre", 32'(bus.ack), 0);
        bus.res_ack = 1'b1;
        step();
        check("t1_ack",     32'(bus.ack), 32'h1);
        check("t1_err",     32'(bus.err), 0);
        check("t1_res_req_done", 32'(bus.res_req), 0);
        bus.req     = '0;
        bus.res_ack = 1'b0;
        step();
        check("t1_ack_drop", 32'(bus.ack), 0);
        check("t1_gnt_drop", 32'(bus.gnt), 0);
        check("t1_busy_idle", 32'(bus.busy), 0);

        // 2: all requesting, immediate res_ack -> grants 0,1,2,3,0
        do_reset();
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_idx = t % 4;
            step();
            check("t2_gnt_idx", 32'(bus.gnt_idx), 32'(exp_idx));
            check("t2_gnt",     32'(bus.gnt), 32'(1) << exp_idx);
            bus.res_ack = 1'b1;
            step();
            check("t2_ack", 32'(bus.ack), 32'(1) << exp_idx);
            check("t2_err", 32'(bus.err), 0);
            bus.res_ack = 1'b0;
            step();
            check("t2_ack_width", 32'(bus.ack), 0);
        end
        bus.req = '0;
        step();

        // 4: res_ack on the timeout cycle counts as success
        bus.req = 4'b0010;
        step();
        step();
        step();
        check("t4_res_req_held", 32'(bus.res_req), 1);
        bus.res_ack = 1'b1;
        step();
        check("t4_ack",  32'(bus.ack), 32'h2);
        check("t4_err",  32'(bus.err), 0);
        check("t4_tcnt", 32'(bus.timeout_cnt), 0);
        bus.req     = '0;
        bus.res_ack = 1'b0;
        step();

        // 3: timeouts on requester 2; counter saturates at 255
        for (int i = 1; i <= 256; i++) begin
            exp_cnt = (i > 255) ? 255 : i;
            bus.req = 4'b0100;
            for (int c = 0; c < int'(TIMEOUT); c++) begin
                step();
                check("t3_res_req_hi", 32'(bus.res_req), 1);
            end
            step();
            check("t3_res_req_lo", 32'(bus.res_req), 0);
            check("t3_ack",  32'(bus.ack), 32'h4);
            check("t3_err",  32'(bus.err), 1);
            check("t3_tcnt", 32'(bus.timeout_cnt), 32'(exp_cnt));
            bus.req = '0;
            step();
        end

        // 5: reset mid-WAIT aborts silently, then requester 1 is served
        bus.req = 4'b0010;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("t5_res_req", 32'(bus.res_req), 0);
        check("t5_gnt",     32'(bus.gnt), 0);
        check("t5_ack",     32'(bus.ack), 0);
        check("t5_tcnt",    32'(bus.timeout_cnt), 0);
        rst_n = 1'b1;
        step();
        check("t5_regnt", 32'(bus.gnt), 32'h2);
        bus.res_ack = 1'b1;
        step();
        check("t5_ack_after", 32'(bus.ack), 32'h2);
        check("t5_err_after", 32'(bus.err), 0);
        bus.req     = '0;
        bus.res_ack = 1'b0;
        step();
        check("t5_no_spurious", 32'(bus.spurious_ack), 0);

        // 6: res_ack while idle sets the sticky flag, no ack issued
        step();
        bus.res_ack = 1'b1;
        step();
        bus.res_ack = 1'b0;
        check("t6_spurious", 32'(bus.spurious_ack), 1);
        check("t6_no_ack",   32'(bus.ack), 0);
        step();
        step();
        check("t6_sticky",   32'(bus.spurious_ack), 1);
        check("t6_idle",     32'(bus.res_req), 0);
        do_reset();
        check("t6_cleared",  32'(bus.spurious_ack), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/req_ack_arbiter.md
Name: req_ack_arbiter

Overview:
- Round-robin arbiter that shares one req/ack-handshake resource among N_REQ requesters.
- Serialises requests, forwards the winner as res_req, and returns a one-cycle ack (or an error ack on timeout) to the winner.
- Enforces the team's bounded-latency rule: every accepted request is acknowledged within a fixed number of cycles.
- Sits between requester masters and the shared responder.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT, 3, max res_ack sample cycles in WAIT before error ack (>=1)
CNT_W, 8, width of saturating timeout event counter

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
req  in  N_REQ  per-requester level request; held until own ack seen
ack  out  N_REQ  one-cycle completion pulse to granted requester
err  out  1  qualifies ack: 1 = completion by timeout
gnt  out  N_REQ  one-hot current grant, 0 when idle
gnt_idx  out  IDX_W  binary index of grant (IDX_W = clog2(N_REQ), min 1)
res_req  out  1  request to shared resource
res_ack  in  1  resource acknowledge
busy  out  1  high in WAIT and DONE
timeout_cnt  out  CNT_W  saturating count of timeouts
spurious_ack  out  1  sticky: res_ack seen while res_req low

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; ack, err, gnt, gnt_idx, res_req, busy, spurious_ack, timeout_cnt all 0.
  - Priority pointer = N_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts it silently: no ack is issued and res_req drops the next cycle.
- FSM states: IDLE, WAIT, DONE.
- IDLE, at edge with |req:
  - Winner = first set bit searching from pointer+1, wrapping modulo N_REQ.
  - Register gnt/gnt_idx, set res_req=1, clear latency counter, go to WAIT.
  - With no req, stay in IDLE.
- WAIT (res_req=1, gnt stable), each edge:
  - res_ack=1: res_req<=0, ack[gnt_idx]<=1, err<=0, go to DONE.
  - Else if latency counter == TIMEOUT-1: res_req<=0, ack[gnt_idx]<=1, err<=1, timeout_cnt+=1 (saturates at all-ones), go to DONE.
  - Else: latency counter +=1.
- DONE (one cycle):
  - ack/err drop to 0; gnt<=0; pointer<=gnt_idx; go to IDLE.
  - Requester must deassert req at the edge it samples ack. A req still high in IDLE is treated as a new request.
- Latency:
  - req sampled in IDLE at edge E0 → ack visible after edge E0+1 (fastest) up to E0+TIMEOUT.
  - Requester sees ack within 2..TIMEOUT+1 cycles of req.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, WAIT, DONE).
- Simultaneous: res_ack arriving on the timeout cycle counts as success (err=0, no count).
- Pointer ownership: a requester that drops req while in WAIT does not cancel the transaction; ack is still pulsed to it.
- spurious_ack: set when res_ack=1 in IDLE or DONE. Cleared only by reset.
- ack is one-hot or zero at all times; gnt is one-hot or zero.

Optional Feature:
REQ_ACK_ARBITER_ASSERT_EN:
- When defined, embedded concurrent assertions on posedge clk, disabled while !rst_n:
  - $onehot0(gnt)
  - $onehot0(ack)
  - res_req |-> ##[1:TIMEOUT] !res_req
  - for each i: req[i] && gnt==0 && state==IDLE && highest priority |-> ##[2:TIMEOUT+1] ack[i]
  - err |-> |ack
- When undefined, no assertion code is compiled and functional behaviour is identical.

Decomposition:
- Package req_ack_arbiter_pkg holds:
  - state enum (IDLE, WAIT, DONE)
  - function rr_pick(req, pointer) returning the winner index
- Sub-module rr_priority_picker (purely combinational round-robin search) instanced once.
- FSM, counters and outputs stay in the top module.

Test Plan:
1. Reset then single req[0] with res_ack one cycle after res_req → ack[0] pulse 2 cycles after req, err=0, gnt=0001 for one WAIT cycle.
2. req=4'b1111 held, res_ack immediate each time → grants in order 0,1,2,3,0; every ack one cycle wide; gnt_idx sequence matches.
3. req[2] with res_ack never asserted, TIMEOUT=3 → res_req high exactly 3 cycles, ack[2]=1 with err=1, timeout_cnt 0→1; repeat 256 times with CNT_W=8 → saturates at 255.
4. res_ack rises on the 3rd WAIT cycle (timeout cycle) → err=0, timeout_cnt unchanged.
5. rst_n low for one cycle mid-WAIT → next cycle res_req=0, gnt=0, no ack; after release req[1] is still served normally.
6. res_ack pulse while idle → spurious_ack=1 and stays high until reset; no ack generated.
